matrix_rand_gen: RTL and testbench
==================================

# matrix_rand_gen

Parametrised successor of the fixed 5x5/8-bit random matrix generator. It collects matrix dimensions and a batch count as ASCII digits from the UART receiver while `current_mode` selects generate mode. It then fills `MAX_DIM x MAX_DIM` matrices with LFSR values constrained to `[val_min, val_max]` and hands each one to matrix storage over a valid/ready handshake. It sits between the UART RX path / mode FSM and the matrix storage block.

## Interface
- `MAX_DIM`, 5: largest row/column count; 1..9, because dimensions are single ASCII digits.
- `ELEM_W`, 8: element width in bits, 2..16.
- `MODE_GEN`, 4'b0010: `current_mode` encoding that enables the block.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `uart_rx_data` in 8: received byte.
- `rx_done` in 1: byte-valid level; the block rising-edge detects it internally.
- `current_mode` in 4: system mode.
- `max_mat_num` in 4: batch count ceiling.
- `val_min`, `val_max` in ELEM_W: element bounds.
- `store_ready` in 1: storage accepts the matrix.
- `mat_m`, `mat_n` out 4: dimensions of the current batch.
- `mat_data_flat` out MAX_DIM*MAX_DIM*ELEM_W: row-major elements; element k at `[k*ELEM_W +: ELEM_W]`; unused elements are 0.
- `mat_count` out 4: clamped batch size.
- `store_en` out 1: matrix valid.
- `input_done` out 1: 1-cycle pulse per accepted matrix.
- `gen_batch_done` out 1: 1-cycle pulse at batch end.
- `error_type` out 3: 000 none, 001 bad dimension, 010 aborted.
- `busy` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, WAIT_M, WAIT_N, WAIT_CNT, GENERATE, STORE, NEXT, DONE.
- A received byte is a qualifying event only when the rx_done rising-edge pulse coincides with `uart_rx_data` in `8'h30`..`8'h39`. Non-digit bytes are ignored in every state.
- IDLE -> WAIT_M:
  - Condition: `current_mode==MODE_GEN` and the finished flag is clear.
  - Actions: clear `error_type`; gen_count=0.
- WAIT_M / WAIT_N, on a digit d:
  - If 1<=d<=MAX_DIM, latch d and advance.
  - Otherwise set `error_type=001` and go to IDLE.
- WAIT_CNT, on a digit d:
  - Target count = 1 if d=0; `max_mat_num` if d>`max_mat_num`; otherwise d.
  - `mat_count` = target count.
  - Load `mat_m`/`mat_n`; total = m*n; elem_idx=0; clear `mat_data_flat`; go to GENERATE.
- GENERATE: writes one element per cycle at elem_idx. After the write at elem_idx = total-1, go to STORE.
- STORE: holds `store_en=1` and a stable `mat_data_flat` until `store_ready` is sampled high. On that cycle:
  - pulse `input_done`;
  - gen_count+1;
  - deassert `store_en` next cycle;
  - go to NEXT.
- NEXT: if gen_count >= target, go to DONE. Otherwise clear the data, set elem_idx=0, and go to GENERATE.
- DONE: pulse `gen_batch_done`, set the finished flag, go to IDLE. The flag clears when `current_mode` != MODE_GEN, so one batch runs per mode entry.
- Element arithmetic:
  - lo/hi = min/max of (`val_min`, `val_max`); swapped bounds are legal.
  - range = hi-lo+1, computed in ELEM_W+1 bits.
  - value = lo + (lfsr[ELEM_W-1:0] mod range), truncated to ELEM_W. A full-scale range yields the raw LFSR bits.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts every cycle in every state. For ELEM_W>16 is illegal.
- Mode exit (`current_mode` != MODE_GEN) in any non-IDLE state:
  - next state IDLE; `store_en` drops the next cycle.
  - If the state was GENERATE, STORE or NEXT, set `error_type=010`; otherwise `error_type` is unchanged.
- The finished flag clears on mode exit, including a mode exit coincident with DONE.

## Timing
- Reset (sync, `rst_n`=0 at a clk edge):
  - state IDLE; lfsr=LFSR_SEED;
  - `mat_m`, `mat_n`, `mat_count`, `mat_data_flat` = 0;
  - `store_en`, `input_done`, `gen_batch_done`, `busy` = 0;
  - `error_type`=000.
- Reset mid-batch discards the matrix with no pulses.
- The rx_done edge detector adds 1 cycle: a byte is acted on 1 cycle after the rx_done rise, and a held-high rx_done counts once.
- Count digit edge -> first element written: 1 cycle. `store_en` rises m*n+1 cycles after the count-digit cycle.
- If `store_ready` is already high, STORE lasts 1 cycle. Per-matrix period = m*n+2 cycles, plus stall cycles.
- `gen_batch_done` is asserted 2 cycles after the last `input_done`.
- A digit arriving during GENERATE/STORE/NEXT/DONE is ignored.

## Configuration
- `MATGEN_ERR_RETRY_EN` defined:
  - An out-of-range dimension digit sets `error_type=001` and the FSM stays in WAIT_M/WAIT_N awaiting a new digit.
  - The next valid digit clears `error_type` to 000.
- Not defined: the FSM returns to IDLE, `error_type` holds 001 until the next entry, and the finished flag is not set, so generation restarts immediately while still in MODE_GEN.

## Test plan
- Defaults, seed ACE1, bounds 0..9, input '2','3','2', `store_ready`=1 -> two matrices 2x3, elements 0..9, elems 6..24 zero, `mat_count`=2, two `input_done` 8 cycles apart, `gen_batch_done` 2 cycles after the second `input_done`.
- `val_min`=20, `val_max`=10, 5x5, count '1' -> all 25 elements in 10..20.
- Digits '6' then, with retry enabled, '4' -> `error_type`=001, then 000, state WAIT_N. Without retry -> IDLE, then immediately WAIT_M.
- `store_ready` low for 7 cycles -> `store_en` high and `mat_data_flat` stable for 8 cycles; exactly one `input_done`.
- `max_mat_num`=3, count '9' -> `mat_count`=3, 3 stores. Count '0' -> `mat_count`=1, 1 store.
- Mode change mid-GENERATE -> IDLE next cycle, `error_type`=010, no `store_en`. `rst_n` low during STORE -> all outputs at reset values at the next edge.

Source files
------------

// File: rtl/matrix_rand_gen.sv
// Random matrix generator: reads m, n and a batch count as ASCII digits, then fills and hands off LFSR matrices.
// Build option MATGEN_ERR_RETRY_EN: a bad dimension digit is reported and re-prompted instead of aborting to IDLE.
module matrix_rand_gen #(
  parameter int          MAX_DIM   = 5,
  parameter int          ELEM_W    = 8,
  parameter logic [3:0]  MODE_GEN  = 4'b0010,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        uart_rx_data,
  input  logic                              rx_done,
  input  logic [3:0]                        current_mode,
  input  logic [3:0]                        max_mat_num,
  input  logic [ELEM_W-1:0]                 val_min,
  input  logic [ELEM_W-1:0]                 val_max,
  input  logic                              store_ready,
  output logic [3:0]                        mat_m,
  output logic [3:0]                        mat_n,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] mat_data_flat,
  output logic [3:0]                        mat_count,
  output logic                              store_en,
  output logic                              input_done,
  output logic                              gen_batch_done,
  output logic [2:0]                        error_type,
  output logic                              busy,
  output logic [2:0]                        dbg_state
);
  localparam int         NELEM     = MAX_DIM * MAX_DIM;
  localparam logic [3:0] MAX_DIM_L = 4'(MAX_DIM);
`ifdef MATGEN_ERR_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_M, S_WAIT_N, S_WAIT_CNT, S_GENERATE, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic        rx_d, rx_evt;
  logic [7:0]  rx_byte;
  logic [3:0]  m_lat, n_lat, target, gen_count;
  logic [7:0]  total, elem_idx;
  logic        finished;

  logic        mode_gen, dig_evt, dim_ok;
  logic [3:0]  digit, cnt_target;
  logic        start, ld_m, ld_n, ld_cnt, set_bad, clr_err, set_abort;
  logic        wr_elem, accept, restart, finish;

  assign mode_gen   = (current_mode == MODE_GEN);
  assign digit      = rx_byte[3:0];
  assign dig_evt    = rx_evt && (rx_byte[7:4] == 4'h3) && (rx_byte[3:0] <= 4'd9);
  assign dim_ok     = (digit != 4'd0) && (digit <= MAX_DIM_L);
  assign cnt_target = (digit == 4'd0) ? 4'd1 : (digit > max_mat_num) ? max_mat_num : digit;

  // Element = lo + (lfsr mod range); range is one bit wider so a full-scale span passes raw LFSR bits.
  logic [ELEM_W-1:0] lo, hi, elem_val;
  logic [ELEM_W:0]   range_w, mod_w;
  assign lo       = (val_min <= val_max) ? val_min : val_max;
  assign hi       = (val_min <= val_max) ? val_max : val_min;
  assign range_w  = {1'b0, hi} - {1'b0, lo} + (ELEM_W+1)'(1);
  assign mod_w    = {1'b0, lfsr[ELEM_W-1:0]} % range_w;
  assign elem_val = ELEM_W'({1'b0, lo} + mod_w);

  // store_en/store_ready: a matrix transfers on the cycle both are high; data is frozen while store_en waits.
  assign store_en  = (state == S_STORE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    ld_m      = 1'b0;
    ld_n      = 1'b0;
    ld_cnt    = 1'b0;
    set_bad   = 1'b0;
    clr_err   = 1'b0;
    set_abort = 1'b0;
    wr_elem   = 1'b0;
    accept    = 1'b0;
    restart   = 1'b0;
    finish    = 1'b0;
    if (state != S_IDLE && !mode_gen) begin
      state_nxt = S_IDLE;
      set_abort = (state == S_GENERATE) || (state == S_STORE) || (state == S_NEXT);
    end else begin
      case (state)
        S_IDLE: if (mode_gen && !finished) begin
          start     = 1'b1;
          state_nxt = S_WAIT_M;
        end
        S_WAIT_M: if (dig_evt) begin
          if (dim_ok) begin
            ld_m      = 1'b1;
            clr_err   = 1'b1;
            state_nxt = S_WAIT_N;
          end else begin
            set_bad   = 1'b1;
            state_nxt = RETRY ? S_WAIT_M : S_IDLE;
          end
        end
        S_WAIT_N: if (dig_evt) begin
          if (dim_ok) begin
            ld_n      = 1'b1;
            clr_err   = 1'b1;
            state_nxt = S_WAIT_CNT;
          end else begin
            set_bad   = 1'b1;
            state_nxt = RETRY ? S_WAIT_N : S_IDLE;
          end
        end
        S_WAIT_CNT: if (dig_evt) begin
          ld_cnt    = 1'b1;
          state_nxt = S_GENERATE;
        end
        S_GENERATE: begin
          wr_elem = 1'b1;
          if (elem_idx == total - 8'd1) state_nxt = S_STORE;
        end
        S_STORE: if (store_ready) begin
          accept    = 1'b1;
          state_nxt = S_NEXT;
        end
        S_NEXT: begin
          if (gen_count >= target) begin
            state_nxt = S_DONE;
          end else begin
            restart   = 1'b1;
            state_nxt = S_GENERATE;
          end
        end
        S_DONE: begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr           <= LFSR_SEED;
      rx_d           <= 1'b0;
      rx_evt         <= 1'b0;
      rx_byte        <= 8'h00;
      m_lat          <= 4'd0;
      n_lat          <= 4'd0;
      target         <= 4'd0;
      gen_count      <= 4'd0;
      total          <= 8'd0;
      elem_idx       <= 8'd0;
      finished       <= 1'b0;
      mat_m          <= 4'd0;
      mat_n          <= 4'd0;
      mat_count      <= 4'd0;
      mat_data_flat  <= '0;
      input_done     <= 1'b0;
      gen_batch_done <= 1'b0;
      error_type     <= 3'b000;
    end else begin
      lfsr           <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rx_d           <= rx_done;
      rx_evt         <= rx_done & ~rx_d;
      rx_byte        <= uart_rx_data;
      input_done     <= accept;
      gen_batch_done <= finish;
      if (!mode_gen)   finished <= 1'b0;
      else if (finish) finished <= 1'b1;
      if (start) begin
        error_type <= 3'b000;
        gen_count  <= 4'd0;
      end
      if (set_bad)   error_type <= 3'b001;
      if (clr_err)   error_type <= 3'b000;
      if (set_abort) error_type <= 3'b010;
      if (ld_m) m_lat <= digit;
      if (ld_n) n_lat <= digit;
      if (ld_cnt) begin
        mat_m         <= m_lat;
        mat_n         <= n_lat;
        total         <= {4'd0, m_lat} * {4'd0, n_lat};
        mat_count     <= cnt_target;
        target        <= cnt_target;
        elem_idx      <= 8'd0;
        mat_data_flat <= '0;
      end
      if (wr_elem) begin
        for (int k = 0; k < NELEM; k++)
          if (elem_idx == 8'(k)) mat_data_flat[k*ELEM_W +: ELEM_W] <= elem_val;
        elem_idx <= elem_idx + 8'd1;
      end
      if (accept) gen_count <= gen_count + 4'd1;
      if (restart) begin
        mat_data_flat <= '0;
        elem_idx      <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_rand_gen.sv
// Bench for matrix_rand_gen: digit-driven batches, scoreboard of expected matrices and metadata per store.
module tb_matrix_rand_gen;
  localparam logic [3:0]  MODE_GEN = 4'b0010;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [2:0]  ST_IDLE = 3'd0, ST_WAIT_M = 3'd1, ST_WAIT_N = 3'd2, ST_WAIT_CNT = 3'd3;

  logic         clk, rst_n, rx_done, store_ready;
  logic [7:0]   uart_rx_data, val_min, val_max;
  logic [3:0]   current_mode, max_mat_num, mat_m, mat_n, mat_count;
  logic [199:0] mat_data_flat;
  logic         store_en, input_done, gen_batch_done, busy;
  logic [2:0]   error_type, dbg_state;

  int           n_vec, n_fail, cyc;
  logic [11:0]  exp_q[$];
  logic [15:0]  hist[$];
  logic [15:0]  lfsr_m;
  logic         prev_se;
  logic [199:0] cap_flat, exp_flat;
  logic [11:0]  mon_e;
  int           mon_t, mon_base;

  matrix_rand_gen dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_data(uart_rx_data), .rx_done(rx_done),
    .current_mode(current_mode), .max_mat_num(max_mat_num), .val_min(val_min), .val_max(val_max),
    .store_ready(store_ready), .mat_m(mat_m), .mat_n(mat_n), .mat_data_flat(mat_data_flat),
    .mat_count(mat_count), .store_en(store_en), .input_done(input_done),
    .gen_batch_done(gen_batch_done), .error_type(error_type), .busy(busy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference LFSR: records the value each edge consumes, so a finished matrix can be rebuilt.
  always @(posedge clk) begin
    if (!rst_n) begin
      lfsr_m = SEED;
      hist.delete();
    end else begin
      hist.push_back(lfsr_m);
      if (hist.size() > 64) void'(hist.pop_front());
      lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  function automatic logic [7:0] elem_model(input logic [15:0] l, input logic [7:0] a, input logic [7:0] b);
    int lo, hi, r, v;
    lo = (a < b) ? int'(a) : int'(b);
    hi = (a < b) ? int'(b) : int'(a);
    r  = hi - lo + 1;
    v  = lo + (int'(l[7:0]) % r);
    return v[7:0];
  endfunction

  // Scoreboard: matrix contents on store_en rise, stability while held, metadata on each input_done.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_se = 1'b0;
    end else begin
      if (store_en && !prev_se) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_store: store_en=1, required no pending matrix");
        end else begin
          mon_e    = exp_q[0];
          mon_t    = int'(mon_e[11:8]) * int'(mon_e[7:4]);
          mon_base = hist.size() - mon_t;
          exp_flat = '0;
          if (mon_base >= 0)
            for (int k = 0; k < mon_t; k++)
              exp_flat[k*8 +: 8] = elem_model(hist[mon_base + k], val_min, val_max);
          if (mat_data_flat !== exp_flat) begin
            n_fail++;
            $display("FAIL elem_data: got %h required %h", mat_data_flat, exp_flat);
          end
        end
        cap_flat = mat_data_flat;
      end else if (store_en) begin
        n_vec++;
        if (mat_data_flat !== cap_flat) begin
          n_fail++;
          $display("FAIL data_stable: got %h required %h", mat_data_flat, cap_flat);
        end
      end
      if (input_done) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_input_done: input_done=1, required 0");
        end else begin
          mon_e = exp_q.pop_front();
          if ({mat_m, mat_n, mat_count} !== mon_e) begin
            n_fail++;
            $display("FAIL store_meta: got m=%0d n=%0d cnt=%0d required m=%0d n=%0d cnt=%0d",
                     mat_m, mat_n, mat_count, mon_e[11:8], mon_e[7:4], mon_e[3:0]);
          end
        end
      end
      prev_se = store_en;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    uart_rx_data = b;
    rx_done      = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic enter_gen();
    current_mode = 4'b0000;
    repeat (2) @(negedge clk);
    current_mode = MODE_GEN;
    repeat (2) @(negedge clk);
    n_vec++;
    if (dbg_state !== ST_WAIT_M) begin
      n_fail++;
      $display("FAIL enter_wait_m: state=%0d required %0d", dbg_state, ST_WAIT_M);
    end
  endtask

  task automatic wait_batch(input int budget, output int n_ido, output bit got);
    n_ido = 0;
    got   = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (input_done) n_ido++;
      if (gen_batch_done) got = 1'b1;
    end
  endtask

  task automatic wait_store(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (store_en) got = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    if (!got) begin
      n_fail++;
      $display("FAIL store_timeout: store_en=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; current_mode = 4'b0000; rx_done = 1'b0; uart_rx_data = 8'h00;
    store_ready = 1'b1; val_min = 8'd0; val_max = 8'd9; max_mat_num = 4'd9;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({mat_m, mat_n, mat_count, store_en, input_done, gen_batch_done, error_type, busy} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: m=%0d n=%0d cnt=%0d se=%b id=%b gbd=%b err=%b busy=%b required all 0",
               mat_m, mat_n, mat_count, store_en, input_done, gen_batch_done, error_type, busy);
    end
    n_vec++;
    if (mat_data_flat !== 200'd0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_data_state: data=%h state=%0d required 0 and IDLE", mat_data_flat, dbg_state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_batch();
    int ido[4];
    int n_ido, gbd;
    bit got, seen;
    n_ido = 0; gbd = 0; got = 1'b0; seen = 1'b0;
    enter_gen();
    send_byte(8'h41);
    n_vec++;
    if (dbg_state !== ST_WAIT_M) begin n_fail++; $display("FAIL nondigit_ignored: state=%0d required %0d", dbg_state, ST_WAIT_M); end
    send_byte(8'h32);
    n_vec++;
    if (dbg_state !== ST_WAIT_N) begin n_fail++; $display("FAIL accept_m: state=%0d required %0d", dbg_state, ST_WAIT_N); end
    send_byte(8'h33);
    n_vec++;
    if (dbg_state !== ST_WAIT_CNT) begin n_fail++; $display("FAIL accept_n: state=%0d required %0d", dbg_state, ST_WAIT_CNT); end
    exp_q.push_back({4'd2, 4'd3, 4'd2});
    exp_q.push_back({4'd2, 4'd3, 4'd2});
    send_byte(8'h32);
    for (int i = 0; i < 200 && !got; i++) begin
      if (store_en && !seen) begin
        seen = 1'b1;
        n_vec++;
        if (mat_data_flat[199:48] !== 152'd0) begin n_fail++; $display("FAIL pad_zero: got %h required 0", mat_data_flat[199:48]); end
        for (int k = 0; k < 6; k++) begin
          n_vec++;
          if (mat_data_flat[k*8 +: 8] > 8'd9) begin n_fail++; $display("FAIL elem_bound: elem %0d=%0d required <=9", k, mat_data_flat[k*8 +: 8]); end
        end
      end
      if (input_done) begin
        if (n_ido < 4) ido[n_ido] = cyc;
        n_ido++;
      end
      if (gen_batch_done) begin gbd = cyc; got = 1'b1; end
      if (!got) @(negedge clk);
    end
    n_vec++;
    if (!got) begin n_fail++; $display("FAIL batch_timeout: gen_batch_done=0, required a pulse"); end
    n_vec++;
    if (n_ido != 2) begin n_fail++; $display("FAIL input_done_count: got %0d required 2", n_ido); end
    if (n_ido >= 2) begin
      n_vec++;
      if (ido[1] - ido[0] != 8) begin n_fail++; $display("FAIL store_period: got %0d required 8", ido[1] - ido[0]); end
      n_vec++;
      if (gbd - ido[1] != 2) begin n_fail++; $display("FAIL batch_done_delay: got %0d required 2", gbd - ido[1]); end
    end
    n_vec++;
    if (mat_count !== 4'd2) begin n_fail++; $display("FAIL mat_count_basic: got %0d required 2", mat_count); end
    repeat (3) @(negedge clk);
    n_vec++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_fail++; $display("FAIL one_batch_per_entry: state=%0d busy=%b required IDLE/0", dbg_state, busy); end
  endtask

  task automatic test_swapped_bounds();
    int n_ido;
    bit got;
    val_min = 8'd20; val_max = 8'd10;
    enter_gen();
    send_byte(8'h35);
    send_byte(8'h35);
    exp_q.push_back({4'd5, 4'd5, 4'd1});
    send_byte(8'h31);
    wait_store(60, got);
    for (int k = 0; k < 25; k++) begin
      n_vec++;
      if (mat_data_flat[k*8 +: 8] < 8'd10 || mat_data_flat[k*8 +: 8] > 8'd20) begin
        n_fail++;
        $display("FAIL swapped_bound: elem %0d=%0d required 10..20", k, mat_data_flat[k*8 +: 8]);
      end
    end
    wait_batch(20, n_ido, got);
    n_vec++;
    if (!got || n_ido != 1) begin n_fail++; $display("FAIL swapped_batch: done=%b stores=%0d required 1/1", got, n_ido); end
    val_min = 8'd0; val_max = 8'd9;
  endtask

  task automatic test_dim_error();
    enter_gen();
    send_byte(8'h36);
`ifdef MATGEN_ERR_RETRY_EN
    n_vec++;
    if (error_type !== 3'b001 || dbg_state !== ST_WAIT_M) begin
      n_fail++;
      $display("FAIL bad_dim_retry: err=%b state=%0d required 001/%0d", error_type, dbg_state, ST_WAIT_M);
    end
`else
    n_vec++;
    if (error_type !== 3'b001 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL bad_dim_abort: err=%b state=%0d required 001/%0d", error_type, dbg_state, ST_IDLE);
    end
    @(negedge clk);
    n_vec++;
    if (error_type !== 3'b000 || dbg_state !== ST_WAIT_M) begin
      n_fail++;
      $display("FAIL bad_dim_reentry: err=%b state=%0d required 000/%0d", error_type, dbg_state, ST_WAIT_M);
    end
`endif
    send_byte(8'h34);
    n_vec++;
    if (error_type !== 3'b000 || dbg_state !== ST_WAIT_N) begin
      n_fail++;
      $display("FAIL good_dim_after_bad: err=%b state=%0d required 000/%0d", error_type, dbg_state, ST_WAIT_N);
    end
  endtask

  task automatic test_stall();
    int n_ido, n_tail, se_cnt;
    bit got;
    n_ido = 0;
    store_ready = 1'b0;
    send_byte(8'h32);
    n_vec++;
    if (dbg_state !== ST_WAIT_CNT) begin n_fail++; $display("FAIL stall_setup: state=%0d required %0d", dbg_state, ST_WAIT_CNT); end
    exp_q.push_back({4'd4, 4'd2, 4'd1});
    send_byte(8'h31);
    wait_store(60, got);
    se_cnt = store_en ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (store_en) se_cnt++;
      if (input_done) n_ido++;
    end
    store_ready = 1'b1;
    @(negedge clk);
    if (input_done) n_ido++;
    n_vec++;
    if (store_en !== 1'b0) begin n_fail++; $display("FAIL store_drop: store_en=%b required 0", store_en); end
    n_vec++;
    if (se_cnt != 8) begin n_fail++; $display("FAIL stall_hold: store_en cycles=%0d required 8", se_cnt); end
    wait_batch(20, n_tail, got);
    n_vec++;
    if (!got || n_ido + n_tail != 1) begin
      n_fail++;
      $display("FAIL stall_accept: done=%b input_done=%0d required 1/1", got, n_ido + n_tail);
    end
  endtask

  task automatic test_count_clamp();
    int n_ido;
    bit got;
    max_mat_num = 4'd3;
    enter_gen();
    uart_rx_data = 8'h31;
    rx_done      = 1'b1;
    repeat (4) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
    n_vec++;
    if (dbg_state !== ST_WAIT_N) begin n_fail++; $display("FAIL held_rx_once: state=%0d required %0d", dbg_state, ST_WAIT_N); end
    send_byte(8'h31);
    repeat (3) exp_q.push_back({4'd1, 4'd1, 4'd3});
    send_byte(8'h39);
    wait_batch(100, n_ido, got);
    n_vec++;
    if (!got || n_ido != 3 || mat_count !== 4'd3) begin
      n_fail++;
      $display("FAIL clamp_high: done=%b stores=%0d cnt=%0d required 1/3/3", got, n_ido, mat_count);
    end
    enter_gen();
    send_byte(8'h31);
    send_byte(8'h32);
    exp_q.push_back({4'd1, 4'd2, 4'd1});
    send_byte(8'h30);
    wait_batch(100, n_ido, got);
    n_vec++;
    if (!got || n_ido != 1 || mat_count !== 4'd1) begin
      n_fail++;
      $display("FAIL clamp_zero: done=%b stores=%0d cnt=%0d required 1/1/1", got, n_ido, mat_count);
    end
    max_mat_num = 4'd9;
  endtask

  task automatic test_mode_abort();
    int n_se;
    n_se = 0;
    enter_gen();
    send_byte(8'h35);
    send_byte(8'h35);
    send_byte(8'h31);
    repeat (3) @(negedge clk);
    current_mode = 4'b0000;
    @(negedge clk);
    n_vec++;
    if (dbg_state !== ST_IDLE || error_type !== 3'b010 || store_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_abort: state=%0d err=%b se=%b busy=%b required IDLE/010/0/0", dbg_state, error_type, store_en, busy);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (store_en || input_done) n_se++;
    end
    n_vec++;
    if (n_se != 0) begin n_fail++; $display("FAIL abort_no_store: active cycles=%0d required 0", n_se); end
  endtask

  task automatic test_reset_in_store();
    bit got;
    store_ready = 1'b0;
    enter_gen();
    send_byte(8'h32);
    send_byte(8'h32);
    exp_q.push_back({4'd2, 4'd2, 4'd1});
    send_byte(8'h31);
    wait_store(60, got);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({mat_m, mat_n, mat_count, store_en, input_done, gen_batch_done, error_type, busy} !== 19'd0 ||
        mat_data_flat !== 200'd0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_in_store: m=%0d n=%0d cnt=%0d se=%b err=%b busy=%b state=%0d required all 0",
               mat_m, mat_n, mat_count, store_en, error_type, busy, dbg_state);
    end
    exp_q.delete();
    current_mode = 4'b0000;
    store_ready  = 1'b1;
    rst_n        = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    test_reset();
    test_basic_batch();
    test_swapped_bounds();
    test_dim_error();
    test_stall();
    test_count_clamp();
    test_mode_abort();
    test_reset_in_store();
    n_vec++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL pending_expected: %0d left required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
